// File: rtl/instruction_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instruction_loader_pkg : shared types and sizing for the IMEM loader        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package instruction_loader_pkg;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } loader_state_t;

  function automatic int ld_beats(input int dw, input int bw);
    return (dw + bw - 1) / bw;
  endfunction

  localparam int LD_DW    = 64;
  localparam int LD_BW    = 32;
  localparam int LD_BEATS = ld_beats(LD_DW, LD_BW);

endpackage
`default_nettype wire

// File: rtl/inst_beat_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_beat_packer : little-endian packing of host beats into one instruction |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module inst_beat_packer
  import instruction_loader_pkg::*;
#(
  parameter int DW    = LD_DW,
  parameter int BW    = LD_BW,
  parameter int BEATS = LD_BEATS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          accept,
  input  logic [BW-1:0] in_data,
  output logic          word_valid,
  output logic [DW-1:0] word
);

  generate
    if (BEATS == 1) begin : g_single
      assign word_valid = accept;
      assign word       = in_data[DW-1:0];
    end else begin : g_multi
      localparam int            IW     = $clog2(BEATS);
      localparam logic [IW-1:0] c_last = IW'(BEATS - 1);

      logic [IW-1:0]           r_idx;
      logic [(BEATS-1)*BW-1:0] r_buf;
      logic [BEATS*BW-1:0]     w_full;

      // The final beat is never stored: it is merged combinationally on the fly.
      assign w_full     = {in_data, r_buf};
      assign word_valid = accept && (r_idx == c_last);
      assign word       = w_full[DW-1:0];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_idx <= '0;
          r_buf <= '0;
        end else if (clr) begin
          r_idx <= '0;
        end else if (accept) begin
          if (r_idx == c_last) begin
            r_idx <= '0;
          end else begin
            r_buf[r_idx*BW +: BW] <= in_data;
            r_idx                 <= r_idx + IW'(1);
          end
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/instruction_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instruction_loader : host beat stream -> packed IMEM writes + live count    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int DW = LD_DW,
  parameter int BW = LD_BW,
  parameter int AW = 8,
  parameter int NW = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] num_instr,
  input  logic [BW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          mem_cen,
  output logic          mem_gwen,
  output logic [DW-1:0] mem_wen,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  output logic [AW-1:0] instruction_count,
  output logic          busy,
  output logic          load_done
);

  localparam int            BEATS       = ld_beats(DW, BW);
  localparam logic [AW-1:0] c_max_instr = ((2**AW - 1) < NW) ? AW'(2**AW - 1) : AW'(NW);

  loader_state_t r_state;
  logic [AW-1:0] r_num;
  logic [AW-1:0] r_accepted;
  logic [AW-1:0] r_count;

  logic          w_start_ok;
  logic          w_accept;
  logic          w_word_valid;
  logic [DW-1:0] w_word;
  logic [AW-1:0] w_num_clamped;
  logic [AW-1:0] w_wr_addr;

  assign w_start_ok        = start && (r_state != LD_LOAD);
  assign w_accept          = in_valid && in_ready;
  assign in_ready          = (r_state == LD_LOAD) && (r_accepted < r_num);
  assign busy              = (r_state == LD_LOAD);
  assign load_done         = (r_state == LD_DONE);
  assign instruction_count = r_count;
  assign w_num_clamped     = (num_instr > c_max_instr) ? c_max_instr : num_instr;
  // A write still in flight bumps the pointer on this same edge, so aim past it.
  assign w_wr_addr         = mem_cen ? r_count : r_count + AW'(1);

  inst_beat_packer #(
    .DW    (DW),
    .BW    (BW),
    .BEATS (BEATS)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (w_start_ok),
    .accept     (w_accept),
    .in_data    (in_data),
    .word_valid (w_word_valid),
    .word       (w_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= LD_IDLE;
      r_num      <= '0;
      r_accepted <= '0;
      r_count    <= '0;
      mem_cen    <= 1'b1;
      mem_gwen   <= 1'b1;
      mem_wen    <= '1;
      mem_a      <= '0;
      mem_d      <= '0;
    end else begin
      mem_cen  <= 1'b1;
      mem_gwen <= 1'b1;
      mem_wen  <= '1;
      // Count trails the write by one cycle so readers never outrun IMEM.
      if (!mem_cen) begin
        r_count <= r_count + AW'(1);
      end
      case (r_state)
        LD_LOAD: begin
          if (w_word_valid) begin
            r_accepted <= r_accepted + AW'(1);
            mem_cen    <= 1'b0;
            mem_gwen   <= 1'b0;
            mem_wen    <= '0;
            mem_a      <= w_wr_addr;
            mem_d      <= w_word;
          end
          if (r_count == r_num) begin
            r_state <= LD_DONE;
          end
        end
        default: begin
          if (start) begin
            r_num      <= w_num_clamped;
            r_accepted <= '0;
            r_count    <= '0;
            r_state    <= (num_instr == '0) ? LD_DONE : LD_LOAD;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instruction_loader : scoreboard bench with IMEM model and fetch reader   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_instruction_loader;

  localparam int DW    = 64;
  localparam int BW    = 32;
  localparam int AW    = 4;
  localparam int NW    = 16;
  localparam int BEATS = (DW + BW - 1) / BW;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] num_instr;
  logic [BW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mem_cen;
  logic          mem_gwen;
  logic [DW-1:0] mem_wen;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic [AW-1:0] instruction_count;
  logic          busy;
  logic          load_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  wr_t           exp_q[$];
  int            wr_cyc[$];
  logic [BW-1:0] beats[$];
  logic [DW-1:0] imem[NW];
  bit            written[NW];
  logic [DW-1:0] prog_exp[NW];
  int            rd_ptr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instruction_loader #(.DW(DW), .BW(BW), .AW(AW), .NW(NW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .num_instr         (num_instr),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .mem_cen           (mem_cen),
    .mem_gwen          (mem_gwen),
    .mem_wen           (mem_wen),
    .mem_a             (mem_a),
    .mem_d             (mem_d),
    .instruction_count (instruction_count),
    .busy              (busy),
    .load_done         (load_done)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endfunction

  // IMEM array model; written[] tracks what the current load has stored.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) written[i] <= 1'b0;
    end else begin
      if (start && !busy) begin
        for (int i = 0; i < NW; i++) written[i] <= 1'b0;
      end
      if (!mem_cen && !mem_gwen) begin
        imem[mem_a]    <= mem_d;
        written[mem_a] <= 1'b1;
      end
    end
  end

  // Fetch side: consumes one instruction per cycle as soon as the count covers it.
  always @(negedge clk) begin
    if (!rst_n || instruction_count == '0) begin
      rd_ptr = 0;
    end else if (rd_ptr < int'(instruction_count)) begin
      chk("fetch_written", 64'(written[rd_ptr]), 64'd1);
      chk("fetch_data", imem[rd_ptr], prog_exp[rd_ptr]);
      rd_ptr++;
    end
  end

  // Write monitor: pops the scoreboard on every IMEM write strobe.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (!mem_cen) begin
        wr_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(mem_a), 64'(e.a));
          chk("wr_data", mem_d, e.d);
          chk("wr_gwen", 64'(mem_gwen), 64'd0);
          chk("wr_wen", mem_wen, 64'd0);
        end
      end else begin
        chk("idle_we", {62'd0, mem_gwen, &mem_wen}, 64'd3);
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_load_done"}, 64'(load_done), 64'd0);
    chk({tag, "_count"}, 64'(instruction_count), 64'd0);
    chk({tag, "_cen"}, 64'(mem_cen), 64'd1);
    chk({tag, "_gwen"}, 64'(mem_gwen), 64'd1);
    chk({tag, "_wen"}, mem_wen, {64{1'b1}});
    chk({tag, "_a"}, 64'(mem_a), 64'd0);
    chk({tag, "_d"}, mem_d, 64'd0);
  endtask

  task automatic new_beats(input int n);
    beats.delete();
    for (int i = 0; i < n * BEATS; i++) beats.push_back(BW'($urandom));
  endtask

  task automatic load(input int n, input bit gaps, input bit poke, input bit timed, input int abort_at);
    logic [BEATS*BW-1:0] tmp;
    wr_t e;
    int  s, b, guard, to, done_c;
    bit  acc;
    for (int i = 0; i < n; i++) begin
      tmp = '0;
      for (int k = 0; k < BEATS; k++) tmp[k*BW +: BW] = beats[i*BEATS + k];
      e.a = AW'(i);
      e.d = tmp[DW-1:0];
      exp_q.push_back(e);
      prog_exp[i] = e.d;
    end
    wr_cyc.delete();
    @(posedge clk); #1;
    start = 1'b1;
    num_instr = AW'(n);
    @(posedge clk); #1;
    s = cyc;
    start = 1'b0;
    num_instr = AW'($urandom);
    in_valid = (n == 0);
    in_data = BW'($urandom);
    @(negedge clk);
    chk("start_busy", 64'(busy), 64'(n != 0));
    chk("start_done", 64'(load_done), 64'(n == 0));
    chk("start_count", 64'(instruction_count), 64'd0);
    chk("start_ready", 64'(in_ready), 64'(n != 0));
    if (n != 0) in_valid = 1'b0;
    b = 0;
    guard = 0;
    while (b < n * BEATS && !(abort_at >= 0 && b == abort_at)) begin
      if (!in_valid) begin
        if (!gaps || $urandom_range(1, 0) == 1) begin
          in_valid = 1'b1;
          in_data = beats[b];
          if (poke && b == 1) begin
            start = 1'b1;
            num_instr = AW'(1);
          end
        end else begin
          in_data = BW'($urandom);
        end
      end
      #1;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) begin
        b++;
        in_valid = 1'b0;
      end
      guard++;
      if (guard > 500) begin
        chk("feed_timeout", 64'd0, 64'd1);
        break;
      end
    end
    if (abort_at >= 0) return;
    to = 0;
    while (!load_done && to < 200) begin
      @(negedge clk);
      to++;
    end
    done_c = cyc;
    chk("done_level", 64'(load_done), 64'd1);
    chk("done_count", 64'(instruction_count), 64'(n));
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_ready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    chk("pending_writes", 64'(exp_q.size()), 64'd0);
    chk("write_count", 64'(wr_cyc.size()), 64'(n));
    if (timed) begin
      for (int i = 0; i < n && i < wr_cyc.size(); i++) chk("wr_cycle", 64'(wr_cyc[i]), 64'(s + 2 + 2 * i));
      chk("done_cycle", 64'(done_c), 64'(s + 2 * n + 2));
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    num_instr = '0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1 check_reset("por");
    @(negedge clk) rst_n = 1'b1;

    new_beats(3);
    load(3, 1'b0, 1'b0, 1'b1, -1);
    load(3, 1'b1, 1'b0, 1'b0, -1);
    load(0, 1'b0, 1'b0, 1'b0, -1);

    new_beats(2);
    load(2, 1'b0, 1'b0, 1'b0, 3);
    #2 rst_n = 1'b0;
    #1 check_reset("midload");
    exp_q.delete();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    new_beats(2);
    load(2, 1'b1, 1'b0, 1'b0, -1);

    new_beats(3);
    load(3, 1'b1, 1'b1, 1'b0, -1);
    new_beats(1);
    load(1, 1'b0, 1'b0, 1'b0, -1);

    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(7, 1);
      new_beats(n);
      load(n, it[0], 1'b0, 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
